// File: rtl/fml_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : fml_arb2
//  Purpose  : Two-master to one-slave FastMemoryLink arbiter. Round-robin
//             grant between master0 and master1, registered command path to
//             the slave, zero-latency done/rdata routing back to the owning
//             master, and a watchdog that aborts a slave that never answers.
//  Ports    :
//    clk, reset               clock, synchronous active-high reset
//    m0_* / m1_*              FML master ports (rd, wr, adr, wdata, msk in;
//                             done, rdata out)
//    s_rd/s_wr/s_adr/
//    s_wdata/s_msk            registered FML command to the slave
//    s_done, s_rdata          slave completion pulse and read data
//    busy                     high while a slave transaction is open
//    owner                    master currently (or last) granted
//    timeout_err              sticky watchdog abort flag
//  Revision : 1.0  initial release
// ============================================================================
module fml_arb2 #(
    parameter int ADR_W   = 22,
    parameter int DAT_W   = 128,
    parameter int MSK_W   = 16,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_rd,
    input  logic             m0_wr,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_wdata,
    input  logic [MSK_W-1:0] m0_msk,
    output logic             m0_done,
    output logic [DAT_W-1:0] m0_rdata,
    input  logic             m1_rd,
    input  logic             m1_wr,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_wdata,
    input  logic [MSK_W-1:0] m1_msk,
    output logic             m1_done,
    output logic [DAT_W-1:0] m1_rdata,
    output logic             s_rd,
    output logic             s_wr,
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_wdata,
    output logic [MSK_W-1:0] s_msk,
    input  logic             s_done,
    input  logic [DAT_W-1:0] s_rdata,
    output logic             busy,
    output logic             owner,
    output logic             timeout_err
);

    localparam logic [0:0]      c_ST_IDLE = 1'b0;
    localparam logic [0:0]      c_ST_BUSY = 1'b1;
    localparam logic [TO_W-1:0] c_TIMEOUT = TO_W'(TIMEOUT);
    localparam logic            c_WD_EN   = (TIMEOUT != 0);

    logic [0:0]       r_state,       w_state_nxt;
    logic             r_owner,       w_owner_nxt;
    logic             r_s_rd,        w_s_rd_nxt;
    logic             r_s_wr,        w_s_wr_nxt;
    logic [ADR_W-1:0] r_s_adr,       w_s_adr_nxt;
    logic [DAT_W-1:0] r_s_wdata,     w_s_wdata_nxt;
    logic [MSK_W-1:0] r_s_msk,       w_s_msk_nxt;
    logic [TO_W-1:0]  r_wdog,        w_wdog_nxt;
    logic             r_timeout_err, w_timeout_err_nxt;

    logic w_act0;
    logic w_act1;
    logic w_gnt1;
    logic w_to_hit;
    logic w_done;

    assign w_act0 = m0_rd | m0_wr;
    assign w_act1 = m1_rd | m1_wr;

    // Master1 wins when it is alone, or when both ask and master0 had the
    // last grant. Reset leaves owner=1 so master0 wins the first contest.
    assign w_gnt1 = w_act1 & (~w_act0 | ~r_owner);

    // Watchdog only fires when the slave is silent in the expiry cycle; a
    // late s_done in that same cycle is taken as a normal completion.
    assign w_to_hit = c_WD_EN & (r_state == c_ST_BUSY) & ~s_done
                    & (r_wdog == c_TIMEOUT);

    // Done is combinational so completion reaches the master with zero
    // latency; it is suppressed under reset so an aborted transaction never
    // reports completion.
    assign w_done = (r_state == c_ST_BUSY) & (s_done | w_to_hit) & ~reset;

    always_comb begin
        w_state_nxt       = r_state;
        w_owner_nxt       = r_owner;
        w_s_rd_nxt        = r_s_rd;
        w_s_wr_nxt        = r_s_wr;
        w_s_adr_nxt       = r_s_adr;
        w_s_wdata_nxt     = r_s_wdata;
        w_s_msk_nxt       = r_s_msk;
        w_wdog_nxt        = r_wdog;
        w_timeout_err_nxt = r_timeout_err;
        case (r_state)
            c_ST_IDLE: begin
                if (w_act0 | w_act1) begin
                    w_state_nxt   = c_ST_BUSY;
                    w_owner_nxt   = w_gnt1;
                    // rd wins over a simultaneous wr
                    w_s_rd_nxt    = w_gnt1 ? m1_rd : m0_rd;
                    w_s_wr_nxt    = w_gnt1 ? (m1_wr & ~m1_rd) : (m0_wr & ~m0_rd);
                    w_s_adr_nxt   = w_gnt1 ? m1_adr   : m0_adr;
                    w_s_wdata_nxt = w_gnt1 ? m1_wdata : m0_wdata;
                    w_s_msk_nxt   = w_gnt1 ? m1_msk   : m0_msk;
                    w_wdog_nxt    = '0;
                end
            end
            c_ST_BUSY: begin
                if (s_done | w_to_hit) begin
                    // Returning to IDLE guarantees a strobe-free cycle
                    // between consecutive slave transactions.
                    w_state_nxt = c_ST_IDLE;
                    w_s_rd_nxt  = 1'b0;
                    w_s_wr_nxt  = 1'b0;
                    if (w_to_hit) begin
                        w_timeout_err_nxt = 1'b1;
                    end
                end else begin
                    w_wdog_nxt = r_wdog + TO_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_owner       <= 1'b1;
            r_s_rd        <= 1'b0;
            r_s_wr        <= 1'b0;
            r_s_adr       <= '0;
            r_s_wdata     <= '0;
            r_s_msk       <= '0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_s_rd        <= w_s_rd_nxt;
            r_s_wr        <= w_s_wr_nxt;
            r_s_adr       <= w_s_adr_nxt;
            r_s_wdata     <= w_s_wdata_nxt;
            r_s_msk       <= w_s_msk_nxt;
            r_wdog        <= w_wdog_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign m0_done     = w_done & ~r_owner;
    assign m1_done     = w_done &  r_owner;
    assign m0_rdata    = s_rdata;
    assign m1_rdata    = s_rdata;
    assign s_rd        = r_s_rd;
    assign s_wr        = r_s_wr;
    assign s_adr       = r_s_adr;
    assign s_wdata     = r_s_wdata;
    assign s_msk       = r_s_msk;
    assign busy        = (r_state == c_ST_BUSY);
    assign owner       = r_owner;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_fml_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fml_arb2
//  Purpose  : Self-checking bench for fml_arb2. Directed scenarios followed by
//             randomized master/slave traffic, all compared every cycle
//             against a transaction-level reference model of the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fml_arb2;

    localparam int ADR_W = 22;
    localparam int DAT_W = 128;
    localparam int MSK_W = 16;
    localparam int TMO   = 15;
    localparam int TO_W  = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       drv_rd;
    logic [1:0]       drv_wr;
    logic [ADR_W-1:0] drv_adr   [2];
    logic [DAT_W-1:0] drv_wdata [2];
    logic [MSK_W-1:0] drv_msk   [2];
    logic             s_done;
    logic [DAT_W-1:0] s_rdata;

    logic             m0_done, m1_done;
    logic [DAT_W-1:0] m0_rdata, m1_rdata;
    logic             s_rd, s_wr;
    logic [ADR_W-1:0] s_adr;
    logic [DAT_W-1:0] s_wdata;
    logic [MSK_W-1:0] s_msk;
    logic             busy, owner, timeout_err;

    always #5 clk = ~clk;

    fml_arb2 #(
        .ADR_W(ADR_W), .DAT_W(DAT_W), .MSK_W(MSK_W), .TIMEOUT(TMO), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_rd(drv_rd[0]), .m0_wr(drv_wr[0]), .m0_adr(drv_adr[0]),
        .m0_wdata(drv_wdata[0]), .m0_msk(drv_msk[0]),
        .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_rd(drv_rd[1]), .m1_wr(drv_wr[1]), .m1_adr(drv_adr[1]),
        .m1_wdata(drv_wdata[1]), .m1_msk(drv_msk[1]),
        .m1_done(m1_done), .m1_rdata(m1_rdata),
        .s_rd(s_rd), .s_wr(s_wr), .s_adr(s_adr), .s_wdata(s_wdata), .s_msk(s_msk),
        .s_done(s_done), .s_rdata(s_rdata),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    // ---------------- reference model state (transaction level) ----------
    bit               e_busy, e_owner, e_terr, e_srd, e_swr;
    logic [ADR_W-1:0] e_adr;
    logic [DAT_W-1:0] e_wdata;
    logic [MSK_W-1:0] e_msk;
    int               e_cnt;      // busy cycles elapsed without completion
    int               sl_cnt;     // slave response delay for current txn
    bit               done_seen [2];
    bit               prev_strobe;
    int               obs_grants [$];

    int n_pass   = 0;
    int n_checks = 0;

    localparam logic [DAT_W-1:0] c_T1_RDATA = 128'hFFEEDDCCBBAA99887766554433221100;

    task automatic check(input string tag, input logic [DAT_W-1:0] act,
                         input logic [DAT_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [DAT_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void model_reset();
        e_busy = 0; e_owner = 1; e_terr = 0; e_srd = 0; e_swr = 0;
        e_adr = '0; e_wdata = '0; e_msk = '0; e_cnt = 0;
    endfunction

    // One clock cycle: compare DUT against the model, advance the model
    // using the inputs currently applied, then move to the next negedge.
    task automatic step();
        bit hit, ed;
        bit a0, a1;
        int k;
        #1;
        if ((s_rd | s_wr) && !prev_strobe) obs_grants.push_back(int'(owner));
        prev_strobe = s_rd | s_wr;
        hit = e_busy && !s_done && (TMO != 0) && (e_cnt == TMO);
        ed  = !reset && e_busy && (s_done || hit);
        check("s_rd", s_rd, e_srd);
        check("s_wr", s_wr, e_swr);
        check("s_adr", s_adr, e_adr);
        check("s_wdata", s_wdata, e_wdata);
        check("s_msk", s_msk, e_msk);
        check("busy", busy, e_busy);
        check("owner", owner, e_owner);
        check("timeout_err", timeout_err, e_terr);
        check("m0_done", m0_done, ed && !e_owner);
        check("m1_done", m1_done, ed && e_owner);
        if (ed && !e_owner) check("m0_rdata", m0_rdata, s_rdata);
        if (ed &&  e_owner) check("m1_rdata", m1_rdata, s_rdata);
        done_seen[0] = ed && !e_owner;
        done_seen[1] = ed && e_owner;

        if (reset) begin
            model_reset();
        end else if (!e_busy) begin
            a0 = drv_rd[0] | drv_wr[0];
            a1 = drv_rd[1] | drv_wr[1];
            if (a0 || a1) begin
                if (a0 && a1) k = e_owner ? 0 : 1;
                else          k = a1 ? 1 : 0;
                e_srd   = drv_rd[k];
                e_swr   = drv_wr[k] && !drv_rd[k];
                e_adr   = drv_adr[k];
                e_wdata = drv_wdata[k];
                e_msk   = drv_msk[k];
                e_owner = (k == 1);
                e_busy  = 1;
                e_cnt   = 0;
                sl_cnt  = $urandom_range(0, 3);
            end
        end else if (s_done || hit) begin
            e_busy = 0; e_srd = 0; e_swr = 0;
            if (hit) e_terr = 1;
        end else begin
            e_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        drv_rd = '0; drv_wr = '0; s_done = 0; s_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            drv_adr[k] = '0; drv_wdata[k] = '0; drv_msk[k] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        step();
        reset = 0;
    endtask

    task automatic new_req(input int k, input int p_both);
        bit op;
        op = 1'($urandom_range(0, 1));
        drv_rd[k]    = op;
        drv_wr[k]    = !op;
        if (int'($urandom_range(0, 99)) < p_both) begin
            drv_rd[k] = 1; drv_wr[k] = 1;
        end
        drv_adr[k]   = ADR_W'($urandom);
        drv_wdata[k] = rand128();
        drv_msk[k]   = MSK_W'($urandom);
    endtask

    task automatic drive_masters(input int p_new, input int p_drop, input int p_both);
        bit pend;
        for (int k = 0; k < 2; k++) begin
            pend = drv_rd[k] | drv_wr[k];
            if (done_seen[k]) begin
                drv_rd[k] = 0; drv_wr[k] = 0; pend = 0;
            end
            if (!pend) begin
                if (int'($urandom_range(0, 99)) < p_new) new_req(k, p_both);
            end else if (int'($urandom_range(0, 99)) < p_drop) begin
                drv_rd[k] = 0; drv_wr[k] = 0;
            end
        end
    endtask

    task automatic drive_slave(input bit hang, input int p_spur);
        s_rdata = rand128();
        if (e_busy) begin
            if (!hang && sl_cnt == 0) s_done = 1;
            else begin
                s_done = 0;
                if (sl_cnt > 0) sl_cnt--;
            end
        end else begin
            s_done = (int'($urandom_range(0, 99)) < p_spur);
        end
    endtask

    initial begin : main
        int n0, dcnt, pulse_at;
        bit drop1;
        clear_inputs();
        prev_strobe = 0;
        done_seen[0] = 0; done_seen[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        reset = 0;
        step();                                   // reset values

        // --- single read from master0 ---
        drv_rd[0] = 1; drv_adr[0] = 22'h000001;
        step();
        #1;
        check("t1_s_rd", s_rd, 1);
        check("t1_s_adr", s_adr, 22'h000001);
        s_done = 1; s_rdata = c_T1_RDATA;
        #1;
        check("t1_m0_done", m0_done, 1);
        check("t1_m0_rdata", m0_rdata, c_T1_RDATA);
        check("t1_m1_done", m1_done, 0);
        step();
        clear_inputs();
        step();

        // --- simultaneous requests after reset ---
        do_reset();
        drv_wr[0] = 1; drv_adr[0] = 22'h5; drv_wdata[0] = rand128(); drv_msk[0] = 16'h00FF;
        drv_rd[1] = 1; drv_adr[1] = 22'h7;
        step();
        #1 check("t2_owner0", owner, 0);
        s_done = 1;
        step();
        drv_wr[0] = 0; s_done = 0;
        #1 check("t2_gap_strobe", s_rd | s_wr, 0);
        step();
        #1 check("t2_owner1", owner, 1);
        check("t2_s_rd", s_rd, 1);
        s_done = 1;
        step();
        clear_inputs();
        step();

        // --- continuous contention: grants must alternate 0,1,0,1 ---
        do_reset();
        n0 = obs_grants.size();
        for (int c = 0; c < 300 && obs_grants.size() < n0 + 9; c++) begin
            drive_masters(100, 0, 0);
            drive_slave(0, 0);
            step();
        end
        check("t3_grants", obs_grants.size() >= n0 + 8, 1);
        for (int i = n0; i < obs_grants.size(); i++)
            check("t3_alt", obs_grants[i], (i - n0) % 2);
        drv_rd = '0; drv_wr = '0;
        for (int c = 0; c < 10 && e_busy; c++) begin
            drive_slave(0, 0);
            step();
        end
        clear_inputs();

        // --- s_done while idle is ignored ---
        step();
        s_done = 1; s_rdata = rand128();
        #1;
        check("t4_m0_done", m0_done, 0);
        check("t4_m1_done", m1_done, 0);
        step();
        s_done = 0;
        #1 check("t4_busy", busy, 0);
        step();

        // --- watchdog: slave never answers master1 write ---
        do_reset();
        drv_wr[1] = 1; drv_adr[1] = ADR_W'($urandom); drv_wdata[1] = rand128();
        step();
        dcnt = 0; pulse_at = -1; drop1 = 0;
        for (int c = 1; c <= 25; c++) begin
            if (drop1) drv_wr[1] = 0;
            s_done = 0;
            #1;
            if (m1_done) begin
                dcnt++; pulse_at = c; drop1 = 1;
            end
            step();
        end
        check("t5_done_cnt", dcnt, 1);
        check("t5_pulse_cycle", pulse_at, TMO + 1);
        check("t5_terr", timeout_err, 1);
        drv_rd[0] = 1; drv_adr[0] = 22'h3;
        step();
        s_done = 1;
        #1 check("t5_m0_done", m0_done, 1);
        step();
        clear_inputs();
        #1 check("t5_terr_sticky", timeout_err, 1);
        step();

        // --- reset while busy ---
        do_reset();
        drv_rd[0] = 1;
        step();
        #1 check("t6_s_rd", s_rd, 1);
        reset = 1; s_done = 1;
        #1 check("t6_no_done", m0_done, 0);
        step();
        reset = 0;
        clear_inputs();
        #1;
        check("t6_s_rd_low", s_rd, 0);
        check("t6_busy", busy, 0);
        check("t6_owner", owner, 1);
        step();

        // --- randomized traffic ---
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive_masters(40, 5, 10);
            drive_slave(0, 10);
            step();
        end
        reset = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fml_arb2.md
Name: fml_arb2

Overview:
- Two-master to one-slave FastMemoryLink (FML) arbiter, placed between FML masters and the DDR controller FML slave port.
- Typical masters: fml_memtest and a second client such as a video or DMA reader.
- Round-robin grant, registered command path to the slave, done/rdata routed back to the owning master.
- Watchdog flags a slave that never completes.

Parameters:
ADR_W, 22, FML address width
DAT_W, 128, FML data width
MSK_W, 16, byte-mask width (DAT_W/8)
TIMEOUT, 1023, max cycles in BUSY before abort; 0 disables watchdog
TO_W, 10, watchdog counter width (must hold TIMEOUT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
m0_rd  in  1  master0 read request
m0_wr  in  1  master0 write request
m0_adr  in  ADR_W  master0 address
m0_wdata  in  DAT_W  master0 write data
m0_msk  in  MSK_W  master0 write mask
m0_done  out  1  master0 completion pulse
m0_rdata  out  DAT_W  read data to master0
m1_* (m1_rd, m1_wr, m1_adr, m1_wdata, m1_msk, m1_done, m1_rdata)  —  same as m0_*, for master1
s_rd  out  1  slave read strobe (registered)
s_wr  out  1  slave write strobe (registered)
s_adr  out  ADR_W  slave address (registered)
s_wdata  out  DAT_W  slave write data (registered)
s_msk  out  MSK_W  slave mask (registered)
s_done  in  1  slave completion pulse
s_rdata  in  DAT_W  slave read data, valid with s_done
busy  out  1  high in BUSY
owner  out  1  master currently or last granted
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: clk, with reset synchronous, active-high.
- Reset values: s_rd=0, s_wr=0, s_adr=0, s_wdata=0, s_msk=0, busy=0, owner=1 (so master0 wins first), timeout_err=0, watchdog=0, state IDLE.
- FML master rules:
  - Request = rd|wr, held with adr/wdata/msk stable until the cycle done=1.
  - rd and wr never both high; if they are, rd wins and wr is ignored.
- States:
  - IDLE: a request is "active" for master k if mk_rd|mk_wr.
    - One active: grant it.
    - Both active: grant the master != owner (round-robin).
    - On grant, at the next edge: s_rd/s_wr/s_adr/s_wdata/s_msk load from the granted master; owner<=k; busy<=1; watchdog<=0; go to BUSY.
    - No active request: stay IDLE.
    - s_done in IDLE is ignored: no mk_done, no state change.
  - BUSY, s_done=1: mk_done=1 combinationally, same cycle, for k=owner only.
    - Next edge: s_rd=s_wr=0, busy=0, go to IDLE.
  - BUSY, s_done=0: watchdog increments.
    - If TIMEOUT!=0 and watchdog==TIMEOUT: mk_done pulses for owner in that cycle; timeout_err<=1 (sticky until reset); next edge behaves as for s_done.
- Latency:
  - Request seen in IDLE cycle N → s_rd/s_wr high in cycle N+1.
  - Completion reaches the master with zero latency.
  - At least one cycle with s_rd=s_wr=0 between consecutive slave transactions.
- Slave outputs stay constant throughout BUSY; the master's inputs are not resampled.
- mk_rdata = s_rdata for both masters, unregistered. Only mk_done qualifies it.
- A master that re-requests in the cycle after its own done loses to a waiting other master (round-robin). It wins if alone.
- A master that drops its request before grant is never issued. A drop after grant does not abort the slave transaction.
- Reset mid-transaction: immediate return to reset values. No done pulse is generated.

Test Plan:
- Reset, then m0_rd=1, m0_adr=0x000001. → s_rd=1, s_adr=0x000001 one cycle later. Slave s_done with s_rdata=0xFFEEDDCCBBAA99887766554433221100 → m0_done=1 and m0_rdata equal in the same cycle; m1_done=0.
- m0_wr and m1_rd both raised in the same cycle after reset. → master0 granted first (owner=0); after its done, m1 is granted with one idle slave cycle between; owner=1.
- Both masters requesting continuously for 8 transactions. → grants strictly alternate 0,1,0,1…; slave never sees two back-to-back strobe cycles without a gap.
- s_done pulsed while IDLE, no requests. → no mk_done, state stays IDLE, busy=0.
- TIMEOUT=15, slave never answers m1_wr. → after 15 BUSY cycles, m1_done pulses once, timeout_err=1 and stays high; the next m0 request is serviced normally.
- Reset asserted during BUSY (s_rd=1). → next cycle s_rd=0, busy=0, owner=1, no done pulse to either master.
